// File: rtl/pc_gen_if.sv
// Fetch PC generator control/status bundle: the pipeline control drives the redirect
// and stall requests (master), and pc_gen returns the fetch address and RAS status (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    // No valid/ready pairs here: requests are level inputs that pc_gen samples on every
    // rising edge, and every output holds its value until the next edge.
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_offset;
    logic            jump_valid;
    logic [XLEN-1:0] jump_target;
    logic            call;
    logic            ret;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] output_PC;
    logic            pc_valid;
    logic            misaligned;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_underflow;

    modport master (
        output stall, branch_taken, branch_offset, jump_valid, jump_target,
               call, ret, trap, trap_vector,
        input  output_PC, pc_valid, misaligned, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump_valid, jump_target,
               call, ret, trap, trap_vector,
        output output_PC, pc_valid, misaligned, ras_empty, ras_full, ras_underflow
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with stall, trap/jump/ret/branch redirect and a
// circular return-address stack; output_PC trails the internal current_pc by one edge.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input logic   clk,
    input logic   reset,
    pc_gen_if.slave bus
);
    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam int              CW         = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(RAS_DEPTH);

    logic [XLEN-1:0] current_pc;
    logic [XLEN-1:0] out_pc_q;
    logic            pc_valid_q;
    logic            misaligned_q;
    logic            underflow_q;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [CW-1:0]   ras_cnt;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic            empty_w;
    logic            misaligned_n;
    logic            underflow_n;
    logic            do_push;
    logic            do_pop;
    logic            do_replace;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;

    assign empty_w = (ras_cnt == '0);
    assign ptr_inc = ras_ptr + PW'(1);
    assign ptr_dec = ras_ptr - PW'(1);

    always_comb begin
        seq_pc       = current_pc + STEP;
        ras_top      = ras_mem[ras_ptr];
        target       = '0;
        redirect     = 1'b0;
        next_pc      = seq_pc;
        underflow_n  = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        do_replace   = 1'b0;
        if (bus.trap) begin
            redirect = 1'b1;
            target   = bus.trap_vector;
        end else if (bus.stall) begin
            next_pc = current_pc;
        end else begin
            if (bus.jump_valid) begin
                redirect = 1'b1;
                target   = bus.jump_target;
            end else if (bus.ret && !empty_w) begin
                redirect = 1'b1;
                target   = ras_top;
            end else if (!bus.ret && bus.branch_taken) begin
                redirect = 1'b1;
                target   = current_pc + bus.branch_offset;
            end
            // The stack moves independently of which source won the PC (link-and-jump,
            // ret under a jump), so these decodes ignore jump_valid and branch_taken.
            underflow_n = bus.ret && empty_w;
            if (bus.call && bus.ret && !empty_w) do_replace = 1'b1;
            else if (bus.call)                   do_push    = 1'b1;
            else if (bus.ret && !empty_w)        do_pop     = 1'b1;
        end
        if (redirect) next_pc = target & ALIGN_MASK;
        misaligned_n = redirect && ((target & ~ALIGN_MASK) != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_pc   <= RESET_VECTOR;
            out_pc_q     <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
            ras_ptr      <= '0;
            ras_cnt      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else begin
            current_pc   <= next_pc;
            misaligned_q <= misaligned_n;
            underflow_q  <= underflow_n;
            if (bus.trap || !bus.stall) begin
                out_pc_q   <= current_pc;
                pc_valid_q <= 1'b1;
            end
            // A push onto a full stack lands on the oldest slot; count saturates.
            if (do_push) begin
                ras_mem[ptr_inc] <= seq_pc;
                ras_ptr          <= ptr_inc;
                if (ras_cnt != DEPTH_C) ras_cnt <= ras_cnt + CW'(1);
            end else if (do_replace) begin
                ras_mem[ras_ptr] <= seq_pc;
            end else if (do_pop) begin
                ras_ptr <= ptr_dec;
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    assign bus.output_PC     = out_pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.misaligned    = misaligned_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.ras_empty     = empty_w;
    assign bus.ras_full      = (ras_cnt == DEPTH_C);
endmodule
